alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequencer and flag owner for the 8-bit ALU datapath.
- Accepts one operation request at a time over a valid/ready handshake and executes it:
  - single-cycle for arithmetic and logic,
  - one bit per cycle for multi-bit shifts and rotates.
- Holds the architectural C/Z/S flag register and returns the result over a valid/ready response channel.
- Sits between the CPU decode/control unit and the register file writeback.

Parameters:
- WIDTH, 8, operand/result width (only 8 supported; fixes flag bit positions).
- CNT_W, 3, width of shift-count field (max shift 7).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  5  operation code (package constants).
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cnt  in  CNT_W  shift/rotate count; ignored for non-shift ops.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_result  out  WIDTH  result.
- resp_err  out  1  illegal opcode flag for this response.
- flag_c  out  1  carry flag register.
- flag_z  out  1  zero flag register.
- flag_s  out  1  sign flag register.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; resp_valid=0, resp_result=0, resp_err=0, flags=0, internal registers 0. Reset mid-operation aborts the operation; no response is produced.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch op/a/b/cnt. Shift-class op (op[4]=1) with cnt!=0 -> SHIFT; otherwise -> EXEC.
  - EXEC: compute the result in one cycle, update flags -> RESP.
  - SHIFT: apply a one-bit step to the working register and C each cycle, decrement the remaining count. Leave for RESP after the step that brings the count to 0.
  - RESP: resp_valid=1 with resp_result and resp_err held stable. On resp_ready -> IDLE.
- Handshake: req_ready is 0 outside IDLE. Outputs are stable while resp_valid=1 and resp_ready=0.
- Latency: request accepted at cycle 0; resp_valid rises at cycle 2 (EXEC) or cycle cnt+1 (SHIFT). Peak throughput is one op per 3 cycles.
- Flag and result rules (Z = result==0, S = result[7] unless noted):
  - ADD: {C,r}=A+B.
  - SUB: {C,r}=A-B (C=borrow).
  - ADC: A+B+C.
  - SBC: A-B-C.
  - AND/OR/XOR, NOT(~A): C=0.
  - INC: B+1, C unchanged.
  - DEC: B-1, C unchanged.
  - CMP: flags as SUB, result=A.
  - TST: flags as AND, result=A.
  - SHL/SAL: C=bit shifted out of bit7, LSB in 0.
  - SHR: logical, C=bit0 out.
  - SAR: MSB replicated, C=bit0 out.
  - ROL/ROR: 8-bit rotate, C=rotated bit.
  - RCL/RCR: 9-bit rotate through C; the working C updates each step.
  - Z/S are evaluated on the final shift result.
- Shift with cnt=0: EXEC path; result=A, C unchanged, Z/S from A.
- Illegal opcodes (01100–01111, 11xxx): EXEC path; result=A, flags unchanged, resp_err=1.
- Flags become visible the cycle state enters RESP. ADC/SBC/RCL/RCR use the flag value at request acceptance.
- All arithmetic is modulo 2^WIDTH; carries are taken from bit WIDTH of a WIDTH+1 sum.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_* 5-bit opcode constants (ADD 00000 … RCR 10111).
  - State enum (IDLE, EXEC, SHIFT, RESP).
  - is_shift/is_legal helper constants or functions.
- One sub-module, alu_shift1: combinational single-bit shift/rotate step.
  - Inputs: value, C_in, op[2:0].
  - Outputs: value, C_out.
  - Used once per SHIFT cycle.

Test Plan:
- Reset then ADD A=0xF0 B=0x20, resp_ready=1 -> resp_valid at cycle 2, result=0x10, C=1 Z=0 S=0, busy low after handshake.
- SUB A=0x05 B=0x05 then SBC A=0x00 B=0x00 -> first result 0x00 Z=1 C=0; with prior C preset via SUB 0x00-0x01 (result 0xFF C=1 S=1), SBC gives 0xFF C=1 S=1.
- RCL A=0x81 cnt=3 with C=0 -> resp_valid at cycle 4, result=0x0A, C=0; SAR A=0x80 cnt=7 -> 0xFF S=1 C=0.
- Backpressure: ADD completes with resp_ready=0 for 5 cycles -> result/flags stable, req_ready=0, a new req_valid is not accepted until the handshake.
- Illegal op 11000 A=0x3C -> result=0x3C, resp_err=1, flags unchanged from the previous op.
- reset_n pulsed low during SHIFT of ROL cnt=7 -> immediately IDLE, flags=0, no resp_valid; the next ADD 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU sequencer: opcodes, FSM states, op-class helpers.
package alu_pkg;

    localparam int ALU_W = 8;

    // Arithmetic / logic class (op[4] = 0)
    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_SUB = 5'b00001;
    localparam logic [4:0] ALU_OP_ADC = 5'b00010;
    localparam logic [4:0] ALU_OP_SBC = 5'b00011;
    localparam logic [4:0] ALU_OP_AND = 5'b00100;
    localparam logic [4:0] ALU_OP_OR  = 5'b00101;
    localparam logic [4:0] ALU_OP_XOR = 5'b00110;
    localparam logic [4:0] ALU_OP_NOT = 5'b00111;
    localparam logic [4:0] ALU_OP_INC = 5'b01000;
    localparam logic [4:0] ALU_OP_DEC = 5'b01001;
    localparam logic [4:0] ALU_OP_CMP = 5'b01010;
    localparam logic [4:0] ALU_OP_TST = 5'b01011;

    // Shift / rotate class (op[4:3] = 10); op[2:0] selects the one-bit step
    localparam logic [4:0] ALU_OP_SHL = 5'b10000;
    localparam logic [4:0] ALU_OP_SAL = 5'b10001;
    localparam logic [4:0] ALU_OP_SHR = 5'b10010;
    localparam logic [4:0] ALU_OP_SAR = 5'b10011;
    localparam logic [4:0] ALU_OP_ROL = 5'b10100;
    localparam logic [4:0] ALU_OP_ROR = 5'b10101;
    localparam logic [4:0] ALU_OP_RCL = 5'b10110;
    localparam logic [4:0] ALU_OP_RCR = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // 11xxx is illegal, so the shift class is exactly 10xxx.
    function automatic logic is_shift(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Illegal: 011xx and 11xxx.
    function automatic logic is_legal(input logic [4:0] op);
        return op[4] ? ~op[3] : ~(op[3] & op[2]);
    endfunction

endpackage

// File: rtl/alu_shift1.sv
// Combinational single-bit shift/rotate step, applied once per SHIFT cycle.
module alu_shift1
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic             c_in,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] value_out,
    output logic             c_out
);

    // Select the one-bit step for the shift/rotate flavour in op[2:0]
    always_comb begin
        value_out = value_in;
        c_out     = c_in;
        case (op)
            3'b000, 3'b001: begin  // SHL / SAL
                value_out = {value_in[WIDTH-2:0], 1'b0};
                c_out     = value_in[WIDTH-1];
            end
            3'b010: begin          // SHR
                value_out = {1'b0, value_in[WIDTH-1:1]};
                c_out     = value_in[0];
            end
            3'b011: begin          // SAR
                value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
                c_out     = value_in[0];
            end
            3'b100: begin          // ROL
                value_out = {value_in[WIDTH-2:0], value_in[WIDTH-1]};
                c_out     = value_in[WIDTH-1];
            end
            3'b101: begin          // ROR
                value_out = {value_in[0], value_in[WIDTH-1:1]};
                c_out     = value_in[0];
            end
            3'b110: begin          // RCL: 9-bit rotate through carry
                value_out = {value_in[WIDTH-2:0], c_in};
                c_out     = value_in[WIDTH-1];
            end
            default: begin         // RCR
                value_out = {c_in, value_in[WIDTH-1:1]};
                c_out     = value_in[0];
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: request handshake, single-cycle arith/logic, bit-serial shifts,
// C/Z/S flag ownership and a held response channel.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CNT_W-1:0] req_cnt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_s,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cw_q;      // carry captured at acceptance, then the working C for shifts

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ex_res;
    logic [WIDTH-1:0] ex_fv;     // value Z/S are taken from (differs from result for CMP/TST)
    logic             ex_c;
    logic             ex_upd;
    logic             ex_err;

    logic [WIDTH-1:0] sh_val;
    logic             sh_c;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    alu_shift1 #(.WIDTH(WIDTH)) u_shift1 (
        .value_in  (work_q),
        .c_in      (cw_q),
        .op        (op_q[2:0]),
        .value_out (sh_val),
        .c_out     (sh_c)
    );

    // Single-cycle result and flag computation for the EXEC state
    always_comb begin
        sum    = '0;
        ex_res = a_q;
        ex_fv  = a_q;
        ex_c   = cw_q;
        ex_upd = 1'b1;
        ex_err = ~is_legal(op_q);
        case (op_q)
            ALU_OP_ADD: begin
                sum    = {1'b0, a_q} + {1'b0, b_q};
                ex_res = sum[WIDTH-1:0];
                ex_c   = sum[WIDTH];
            end
            ALU_OP_SUB: begin
                sum    = {1'b0, a_q} - {1'b0, b_q};
                ex_res = sum[WIDTH-1:0];
                ex_c   = sum[WIDTH];
            end
            ALU_OP_ADC: begin
                sum    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cw_q};
                ex_res = sum[WIDTH-1:0];
                ex_c   = sum[WIDTH];
            end
            ALU_OP_SBC: begin
                sum    = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cw_q};
                ex_res = sum[WIDTH-1:0];
                ex_c   = sum[WIDTH];
            end
            ALU_OP_AND: begin ex_res = a_q & b_q; ex_c = 1'b0; end
            ALU_OP_OR:  begin ex_res = a_q | b_q; ex_c = 1'b0; end
            ALU_OP_XOR: begin ex_res = a_q ^ b_q; ex_c = 1'b0; end
            ALU_OP_NOT: begin ex_res = ~a_q;      ex_c = 1'b0; end
            ALU_OP_INC: ex_res = b_q + WIDTH'(1);
            ALU_OP_DEC: ex_res = b_q - WIDTH'(1);
            ALU_OP_CMP: begin
                sum   = {1'b0, a_q} - {1'b0, b_q};
                ex_c  = sum[WIDTH];
                ex_fv = sum[WIDTH-1:0];
            end
            ALU_OP_TST: begin
                ex_fv = a_q & b_q;
                ex_c  = 1'b0;
            end
            ALU_OP_SHL, ALU_OP_SAL, ALU_OP_SHR, ALU_OP_SAR,
            ALU_OP_ROL, ALU_OP_ROR, ALU_OP_RCL, ALU_OP_RCR: begin
                // count of zero: pass A through, keep C, Z/S from A
            end
            default: ex_upd = 1'b0;  // illegal: flags untouched
        endcase
        if (ex_upd) begin
            ex_fv = (op_q == ALU_OP_CMP || op_q == ALU_OP_TST) ? ex_fv : ex_res;
        end
    end

    // Sequencer FSM with registered response and flag outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            cw_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_s      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        a_q    <= req_a;
                        b_q    <= req_b;
                        work_q <= req_a;
                        cnt_q  <= req_cnt;
                        cw_q   <= flag_c;
                        state  <= (is_shift(req_op) && req_cnt != '0) ? ST_SHIFT : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result <= ex_res;
                    resp_err    <= ex_err;
                    resp_valid  <= 1'b1;
                    if (ex_upd) begin
                        flag_c <= ex_c;
                        flag_z <= (ex_fv == '0);
                        flag_s <= ex_fv[WIDTH-1];
                    end
                    state <= ST_RESP;
                end
                ST_SHIFT: begin
                    work_q <= sh_val;
                    cw_q   <= sh_c;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        resp_result <= sh_val;
                        resp_err    <= 1'b0;
                        resp_valid  <= 1'b1;
                        flag_c      <= sh_c;
                        flag_z      <= (sh_val == '0);
                        flag_s      <= sh_val[WIDTH-1];
                        state       <= ST_RESP;
                    end
                end
                default: begin  // ST_RESP
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// against a behavioural model built from whole-value arithmetic.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_cnt;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_result;
    logic       resp_err;
    logic       flag_c;
    logic       flag_z;
    logic       flag_s;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // model flag state
    logic mc, mz, ms;

    // expected values of the last op
    logic [7:0] exp_res;
    logic       exp_err;
    logic [2:0] exp_f;
    int         exp_lat;

    // observed values of the last op
    logic [7:0] obs_res;
    logic       obs_err;
    logic [2:0] obs_f;
    int         obs_lat;
    logic       obs_acc_rdy;
    logic       obs_stable;
    logic       obs_idle;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_cnt     (req_cnt),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .flag_s      (flag_s),
        .busy        (busy)
    );

    // Behavioural reference: whole-value arithmetic and multi-bit rotates.
    function automatic void model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] cnt, input logic ci, input logic zi, input logic si,
                                  output logic [7:0] r, output logic e, output logic co,
                                  output logic zo, output logic so, output int lat);
        int ai, bi, t, n;
        logic [15:0] x;
        logic [17:0] y;
        logic [8:0]  v;
        logic [7:0]  f;
        logic        upd;
        ai = int'(a); bi = int'(b); n = int'(cnt); t = 0; x = '0; y = '0;
        v = {ci, a}; r = a; f = a; e = 1'b0; co = ci; upd = 1'b1; lat = 2;
        if (op[4:3] == 2'b10) begin
            if (n != 0) begin
                lat = n + 1;
                case (op[2:0])
                    3'd0, 3'd1: begin x = {8'h00, a} << n; r = x[7:0]; co = x[8]; end
                    3'd2: begin x = {a, 8'h00} >> n; r = x[15:8]; co = x[7]; end
                    3'd3: begin x = $signed({a, 8'h00}) >>> n; r = x[15:8]; co = x[7]; end
                    3'd4: begin x = {a, a} << n; r = x[15:8]; co = r[0]; end
                    3'd5: begin x = {a, a} >> n; r = x[7:0]; co = r[7]; end
                    3'd6: begin y = {v, v} << n; r = y[16:9]; co = y[17]; end
                    default: begin y = {v, v} >> n; r = y[7:0]; co = y[8]; end
                endcase
                f = r;
            end
        end else if (op[4] || op[3:2] == 2'b11) begin
            e = 1'b1; upd = 1'b0;
        end else begin
            case (op)
                ALU_OP_ADD: begin t = ai + bi;            r = t[7:0]; co = (t > 255); end
                ALU_OP_SUB: begin t = ai - bi;            r = t[7:0]; co = (t < 0);   end
                ALU_OP_ADC: begin t = ai + bi + int'(ci); r = t[7:0]; co = (t > 255); end
                ALU_OP_SBC: begin t = ai - bi - int'(ci); r = t[7:0]; co = (t < 0);   end
                ALU_OP_AND: begin r = a & b; co = 1'b0; end
                ALU_OP_OR:  begin r = a | b; co = 1'b0; end
                ALU_OP_XOR: begin r = a ^ b; co = 1'b0; end
                ALU_OP_NOT: begin r = ~a;    co = 1'b0; end
                ALU_OP_INC: begin t = bi + 1; r = t[7:0]; end
                ALU_OP_DEC: begin t = bi - 1; r = t[7:0]; end
                ALU_OP_CMP: begin t = ai - bi; r = a; co = (t < 0); end
                default:    begin r = a; co = 1'b0; end  // TST
            endcase
            if (op == ALU_OP_CMP) f = t[7:0];
            else if (op == ALU_OP_TST) f = a & b;
            else f = r;
        end
        if (upd) begin zo = (f == 8'h00); so = f[7]; end
        else begin zo = zi; so = si; end
    endfunction

    // Drive one request, wait for the response, optionally stall it, then complete the handshake.
    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] cnt, input int stall, input bit intrude);
        logic nc, nz, ns;
        int n;
        model(op, a, b, cnt, mc, mz, ms, exp_res, exp_err, nc, nz, ns, exp_lat);
        exp_f = {nc, nz, ns};
        obs_acc_rdy = req_ready;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cnt = cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 5'($urandom); req_a = 8'($urandom);
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        obs_lat = resp_valid ? n : -1;
        obs_res = resp_result; obs_err = resp_err; obs_f = {flag_c, flag_z, flag_s};
        obs_stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (intrude) begin
                req_valid = 1'b1; req_op = ALU_OP_ADD; req_a = 8'h11; req_b = 8'h22; req_cnt = 3'd0;
            end
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_result !== obs_res || resp_err !== obs_err ||
                {flag_c, flag_z, flag_s} !== obs_f || req_ready !== 1'b0 || busy !== 1'b1)
                obs_stable = 1'b0;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        obs_idle = (resp_valid === 1'b0 && busy === 1'b0 && req_ready === 1'b1);
        mc = nc; mz = nz; ms = ns;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_cnt = '0;
        mc = 1'b0; mz = 1'b0; ms = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_result, resp_err, flag_c, flag_z, flag_s, busy, req_ready} !== 15'h0001) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%h e=%b f=%b%b%b busy=%b rdy=%b, want all 0 and rdy=1",
                     resp_valid, resp_result, resp_err, flag_c, flag_z, flag_s, busy, req_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_op(ALU_OP_ADD, 8'hF0, 8'h20, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'h10 || obs_f !== 3'b100) begin
            errors++; $display("FAIL add_result: got r=%h CZS=%b, want r=10 CZS=100", obs_res, obs_f);
        end
        checks++;
        if (obs_lat !== 2 || obs_acc_rdy !== 1'b1) begin
            errors++; $display("FAIL add_latency: got lat=%0d rdy=%b, want lat=2 rdy=1", obs_lat, obs_acc_rdy);
        end
        checks++;
        if (obs_idle !== 1'b1) begin
            errors++; $display("FAIL add_idle_after: got idle=%b, want 1", obs_idle);
        end
    endtask

    task automatic test_sub_sbc();
        run_op(ALU_OP_SUB, 8'h05, 8'h05, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'h00 || obs_f !== 3'b010) begin
            errors++; $display("FAIL sub_equal: got r=%h CZS=%b, want r=00 CZS=010", obs_res, obs_f);
        end
        run_op(ALU_OP_SUB, 8'h00, 8'h01, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'hFF || obs_f !== 3'b101) begin
            errors++; $display("FAIL sub_borrow: got r=%h CZS=%b, want r=ff CZS=101", obs_res, obs_f);
        end
        run_op(ALU_OP_SBC, 8'h00, 8'h00, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'hFF || obs_f !== 3'b101) begin
            errors++; $display("FAIL sbc_with_c: got r=%h CZS=%b, want r=ff CZS=101", obs_res, obs_f);
        end
    endtask

    task automatic test_shift();
        run_op(ALU_OP_AND, 8'h00, 8'h00, 3'd0, 0, 1'b0);  // clears C
        run_op(ALU_OP_RCL, 8'h81, 8'h00, 3'd3, 0, 1'b0);
        checks++;
        if (obs_res !== 8'h0A || obs_f[2] !== 1'b0 || obs_lat !== 4) begin
            errors++; $display("FAIL rcl3: got r=%h C=%b lat=%0d, want r=0a C=0 lat=4", obs_res, obs_f[2], obs_lat);
        end
        run_op(ALU_OP_SAR, 8'h80, 8'h00, 3'd7, 0, 1'b0);
        checks++;
        if (obs_res !== 8'hFF || obs_f !== 3'b001 || obs_lat !== 8) begin
            errors++; $display("FAIL sar7: got r=%h CZS=%b lat=%0d, want r=ff CZS=001 lat=8", obs_res, obs_f, obs_lat);
        end
        run_op(ALU_OP_SHL, 8'h00, 8'h00, 3'd0, 0, 1'b0);  // count 0: A through, C kept, Z from A
        checks++;
        if (obs_res !== 8'h00 || obs_f !== 3'b010 || obs_lat !== 2) begin
            errors++; $display("FAIL shl0: got r=%h CZS=%b lat=%0d, want r=00 CZS=010 lat=2", obs_res, obs_f, obs_lat);
        end
    endtask

    task automatic test_backpressure();
        run_op(ALU_OP_ADD, 8'h7F, 8'h01, 3'd0, 5, 1'b1);
        checks++;
        if (obs_stable !== 1'b1 || obs_res !== 8'h80 || obs_f !== 3'b001) begin
            errors++; $display("FAIL backpressure: got stable=%b r=%h CZS=%b, want stable=1 r=80 CZS=001",
                               obs_stable, obs_res, obs_f);
        end
        checks++;
        if (obs_idle !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: got idle=%b, want 1", obs_idle);
        end
    endtask

    task automatic test_illegal();
        run_op(ALU_OP_SUB, 8'h00, 8'h01, 3'd0, 0, 1'b0);
        run_op(5'b11000, 8'h3C, 8'h55, 3'd2, 0, 1'b0);
        checks++;
        if (obs_res !== 8'h3C || obs_err !== 1'b1 || obs_f !== 3'b101 || obs_lat !== 2) begin
            errors++; $display("FAIL illegal_op: got r=%h err=%b CZS=%b lat=%0d, want r=3c err=1 CZS=101 lat=2",
                               obs_res, obs_err, obs_f, obs_lat);
        end
        run_op(5'b01101, 8'hA5, 8'h00, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'hA5 || obs_err !== 1'b1 || obs_f !== 3'b101) begin
            errors++; $display("FAIL illegal_01101: got r=%h err=%b CZS=%b, want r=a5 err=1 CZS=101",
                               obs_res, obs_err, obs_f);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        req_valid = 1'b1; req_op = ALU_OP_ROL; req_a = 8'h96; req_b = 8'h00; req_cnt = 3'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, req_ready, resp_valid, flag_c, flag_z, flag_s} !== 6'b010000) begin
            errors++; $display("FAIL reset_mid_shift: got busy=%b rdy=%b v=%b CZS=%b%b%b, want 0 1 0 000",
                               busy, req_ready, resp_valid, flag_c, flag_z, flag_s);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        mc = 1'b0; mz = 1'b0; ms = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_no_resp: got resp_valid seen=%b, want 0", seen);
        end
        run_op(ALU_OP_ADD, 8'h01, 8'h01, 3'd0, 0, 1'b0);
        checks++;
        if (obs_res !== 8'h02 || obs_f !== 3'b000) begin
            errors++; $display("FAIL add_after_reset: got r=%h CZS=%b, want r=02 CZS=000", obs_res, obs_f);
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int k = 0; k < 300; k++) begin
            op = 5'($urandom_range(0, 31));
            run_op(op, 8'($urandom), 8'($urandom), 3'($urandom), (k % 4 == 0) ? int'($urandom_range(0, 3)) : 0, 1'b0);
            checks++;
            if ({obs_res, obs_err, obs_f} !== {exp_res, exp_err, exp_f} || obs_lat !== exp_lat ||
                obs_stable !== 1'b1 || obs_idle !== 1'b1 || obs_acc_rdy !== 1'b1) begin
                errors++;
                $display("FAIL random_op%0d op=%b: got r=%h e=%b CZS=%b lat=%0d stb=%b idle=%b, want r=%h e=%b CZS=%b lat=%0d stb=1 idle=1",
                         k, op, obs_res, obs_err, obs_f, obs_lat, obs_stable, obs_idle,
                         exp_res, exp_err, exp_f, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_sbc();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
